// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_if
//  Description : UART byte input and code-memory load / run outputs of the
//                serial program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface program_loader_if #(
    parameter int ADDR_W = 9
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              code_w_en;
    logic [ADDR_W-1:0] code_addr_in;
    logic [15:0]       code_in;
    logic              run;
    logic              busy;
    logic              err;

    modport master (
        output rx_valid, rx_data,
        input  code_w_en, code_addr_in, code_in, run, busy, err
    );

    modport slave (
        input  rx_valid, rx_data,
        output code_w_en, code_addr_in, code_in, run, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Parses a framed, XOR-checksummed program image from a UART
//                byte stream, writes it into code memory and releases run.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 512
) (
    input wire logic          clk,
    input wire logic          rst,
    program_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CNT_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_CHECK   = 3'd4,
        S_RUN     = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam logic [10:0] c_MAX_WORDS = 11'(MAX_WORDS);

    state_t     r_state;
    logic [7:0] r_cnt_hi;
    logic [9:0] r_count;
    logic [9:0] r_idx;
    logic [7:0] r_hi;
    logic [7:0] r_chk;

    logic [9:0] w_count;
    logic       w_count_bad;
    logic       w_last_word;

    assign w_count     = {r_cnt_hi[1:0], bus.rx_data};
    assign w_count_bad = (r_cnt_hi[7:2] != 6'd0) || (w_count == 10'd0) ||
                         ({1'b0, w_count} > c_MAX_WORDS);
    assign w_last_word = (r_idx + 10'd1) == r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt_hi         <= 8'd0;
            r_count          <= 10'd0;
            r_idx            <= 10'd0;
            r_hi             <= 8'd0;
            r_chk            <= 8'd0;
            bus.code_w_en    <= 1'b0;
            bus.code_addr_in <= '0;
            bus.code_in      <= 16'd0;
            bus.run          <= 1'b0;
            bus.busy         <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            bus.code_w_en <= 1'b0;
            if (bus.rx_valid) begin
                case (r_state)
                    S_IDLE: begin
                        // Checksum restarts from zero, so the first byte is the running value.
                        r_cnt_hi <= bus.rx_data;
                        r_chk    <= bus.rx_data;
                        bus.busy <= 1'b1;
                        r_state  <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        r_chk <= r_chk ^ bus.rx_data;
                        if (w_count_bad) begin
                            bus.busy <= 1'b0;
                            bus.err  <= 1'b1;
                            r_state  <= S_ERR;
                        end else begin
                            r_count <= w_count;
                            r_state <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        r_hi    <= bus.rx_data;
                        r_chk   <= r_chk ^ bus.rx_data;
                        r_state <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        r_chk            <= r_chk ^ bus.rx_data;
                        bus.code_in      <= {r_hi, bus.rx_data};
                        bus.code_addr_in <= ADDR_W'(r_idx);
                        bus.code_w_en    <= 1'b1;
                        r_idx            <= r_idx + 10'd1;
                        r_state          <= w_last_word ? S_CHECK : S_DATA_HI;
                    end
                    S_CHECK: begin
                        bus.busy <= 1'b0;
                        if (bus.rx_data == r_chk) begin
                            bus.run <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            bus.err <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                    default: begin
                        // RUN and ERR hold until reset; strobes are ignored.
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Randomised self-checking bench for program_loader against a
//                byte-position frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int c_ADDR_W    = 9;
    localparam int c_MAX_WORDS = 512;

    logic clk;
    logic rst;

    program_loader_if #(.ADDR_W(c_ADDR_W)) bus ();

    program_loader #(
        .ADDR_W    (c_ADDR_W),
        .MAX_WORDS (c_MAX_WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: tracks the frame purely by byte position.
    int          m_pos;
    int          m_cnt;
    int          m_fin;       // 0 loading, 1 run, 2 error
    logic [7:0]  m_hdr;
    logic [7:0]  m_hi;
    logic [7:0]  m_sum;
    logic        exp_wen;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_busy;

    logic [7:0]  frame[$];
    logic [15:0] wq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".w_en"}, 32'(bus.code_w_en), 32'(exp_wen));
        check({tag, ".addr"}, 32'(bus.code_addr_in), 32'(exp_addr));
        check({tag, ".data"}, 32'(bus.code_in), 32'(exp_data));
        check({tag, ".run"}, 32'(bus.run), 32'(m_fin == 1));
        check({tag, ".err"}, 32'(bus.err), 32'(m_fin == 2));
        check({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    endtask

    task automatic model_reset();
        m_pos = 0; m_cnt = 0; m_fin = 0;
        m_hdr = 8'd0; m_hi = 8'd0; m_sum = 8'd0;
        exp_wen = 1'b0; exp_addr = 16'd0; exp_data = 16'd0; exp_busy = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_wen = 1'b0;
        if (m_fin == 0) begin
            if (m_pos == 0) begin
                m_hdr = b;
                m_sum = b;
                exp_busy = 1'b1;
            end else if (m_pos == 1) begin
                m_cnt = int'(m_hdr[1:0]) * 256 + int'(b);
                m_sum = m_sum ^ b;
                if (m_hdr[7:2] != 6'd0 || m_cnt == 0 || m_cnt > c_MAX_WORDS) begin
                    m_fin = 2;
                    exp_busy = 1'b0;
                end
            end else if (m_pos < 2 + 2 * m_cnt) begin
                m_sum = m_sum ^ b;
                if ((m_pos - 2) % 2 == 0) begin
                    m_hi = b;
                end else begin
                    exp_wen  = 1'b1;
                    exp_addr = 16'((m_pos - 3) / 2);
                    exp_data = {m_hi, b};
                end
            end else begin
                m_fin = (b == m_sum) ? 1 : 2;
                exp_busy = 1'b0;
            end
            m_pos++;
        end
    endtask

    task automatic put(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        model_byte(b);
        compare_all("byte");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_wen = 1'b0;
            compare_all("idle");
        end
    endtask

    task automatic do_reset(input logic strobe, input logic [7:0] b);
        rst = 1'b1;
        bus.rx_valid = strobe;
        bus.rx_data  = b;
        @(negedge clk);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        model_reset();
        compare_all("reset");
    endtask

    task automatic build_frame(input logic [7:0] chk_flip);
        logic [7:0] s;
        int n;
        n = wq.size();
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        foreach (wq[i]) begin
            frame.push_back(wq[i][15:8]);
            frame.push_back(wq[i][7:0]);
        end
        s = 8'd0;
        foreach (frame[i]) s = s ^ frame[i];
        frame.push_back(s ^ chk_flip);
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frame[i]) begin
            put(frame[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0, 8'd0);

        // Single word, spec example bytes.
        put(8'h00); put(8'h01); put(8'h12); put(8'h34); put(8'h27);
        idle(2);

        // Three words back-to-back.
        do_reset(1'b0, 8'd0);
        wq = '{16'hA001, 16'hB002, 16'hC003};
        build_frame(8'h00);
        send_frame(0);
        idle(2);

        // Bad checksum, then trailing bytes must be ignored.
        do_reset(1'b0, 8'd0);
        put(8'h00); put(8'h01); put(8'h12); put(8'h34); put(8'h28);
        put(8'h00); put(8'h01); put(8'h55); put(8'hAA);
        idle(1);

        // Bad counts: zero, 513, nonzero reserved header bits.
        do_reset(1'b0, 8'd0);
        put(8'h00); put(8'h00); put(8'h12); put(8'h34);
        do_reset(1'b0, 8'd0);
        put(8'h02); put(8'h01); put(8'h12); put(8'h34);
        do_reset(1'b0, 8'd0);
        put(8'h04); put(8'h01); put(8'h12); put(8'h34);

        // Full 512-word image.
        do_reset(1'b0, 8'd0);
        wq.delete();
        for (int i = 0; i < c_MAX_WORDS; i++) wq.push_back(16'(i) ^ 16'h5A5A);
        build_frame(8'h00);
        send_frame(0);
        check("max.last_addr", 32'(bus.code_addr_in), 32'd511);
        idle(2);

        // Reset after 2 of 4 words, then a fresh two-word frame.
        do_reset(1'b0, 8'd0);
        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        build_frame(8'h00);
        for (int i = 0; i < 6; i++) put(frame[i]);
        do_reset(1'b0, 8'd0);
        wq = '{16'hBEEF, 16'hCAFE};
        build_frame(8'h00);
        send_frame(1);
        idle(1);

        // Reset coincident with a strobe: that byte must be dropped.
        do_reset(1'b1, 8'h00);
        wq = '{16'h0F0F};
        build_frame(8'h00);
        send_frame(0);

        // Randomised frames: good, corrupted checksum, or random header.
        for (int t = 0; t < 20; t++) begin
            int kind;
            do_reset(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            wq.delete();
            for (int i = 0; i < int'($urandom_range(1, 24)); i++)
                wq.push_back(16'($urandom_range(0, 65535)));
            kind = int'($urandom_range(0, 5));
            build_frame(kind == 0 ? 8'($urandom_range(1, 255)) : 8'h00);
            if (kind == 1) frame[0] = 8'($urandom_range(0, 255));
            send_frame(2);
            for (int i = 0; i < 3; i++) put(8'($urandom_range(0, 255)));
        end

        do_reset(1'b0, 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Serial boot loader that sits directly upstream of the processor datapath and drives its code-memory load port (`code_w_en`, `code_addr_in`, `code_in`) and its `run` input. It consumes a byte stream from the board UART receiver, parses a framed program image, writes each 16-bit instruction word into code memory at consecutive addresses, and verifies an XOR checksum. On a good checksum it releases the processor; on any framing or checksum fault it holds the processor stopped and flags an error.

## Interface

- `ADDR_W`, 9: code memory address width; the code memory is 512 words.
- `MAX_WORDS`, 512: largest accepted image, in words. Must not exceed 2^ADDR_W.

- `clk`  in  1  system clock, shared with datapath.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` holds a received byte.
- `rx_data`  in  8  received byte. Sampled only when `rx_valid`=1.
- `code_w_en`  out  1  code memory write enable. Goes to datapath `code_w_en`.
- `code_addr_in`  out  ADDR_W  code memory write address.
- `code_in`  out  16  code memory write data.
- `run`  out  1  processor run enable. Goes to datapath `run`.
- `busy`  out  1  a frame is in progress; high after the first header byte until the load finishes or faults.
- `err`  out  1  the load faulted. Sticky until `rst`.

## Operation

- Frame format, bytes in order:
  - `CNT_HI`: bits [1:0] = count[9:8]; bits [7:2] must be 0.
  - `CNT_LO`: count[7:0].
  - count words, each sent as high byte then low byte.
  - `CHK`: XOR of every preceding byte in the frame, headers included.
- Valid count is 1..MAX_WORDS. A count of 0, a count above MAX_WORDS, or nonzero `CNT_HI`[7:2] sends the FSM to `ERR`. The count is checked on the `CNT_LO` byte.
- FSM states and transitions, each taken on an accepted byte unless noted:
  - `IDLE` -> `CNT_LO`
  - `CNT_LO` -> `DATA_HI`, or `ERR` if the count is bad
  - `DATA_HI` -> `DATA_LO`
  - `DATA_LO` -> `DATA_HI` if more words remain; otherwise -> `CHECK`
  - `CHECK` -> `RUN` if the checksum matches, else -> `ERR`
  - `RUN` and `ERR` are terminal. Further `rx_valid` strobes are ignored; only `rst` leaves them.
- Word assembly: the high byte is latched in `DATA_HI`. On the low byte, `code_in`={hi,lo} and `code_addr_in`=word index are registered, and `code_w_en` pulses for exactly one cycle.
- Word index starts at 0 and increments after each write. Word k is written to address k. There is no wrap: the count check guarantees index ≤ MAX_WORDS-1.
- Running checksum: cleared in `IDLE`, XORed with every accepted byte before `CHK`. It is compared with the `CHK` byte.
- `run`=1 only in `RUN`. `err`=1 only in `ERR`. `busy`=1 in `CNT_LO`, `DATA_HI`, `DATA_LO` and `CHECK`.
- `run` and `code_w_en` are never high in the same cycle.

## Timing

- Reset values: state=`IDLE`, `code_w_en`=0, `code_addr_in`=0, `code_in`=0, `run`=0, `busy`=0, `err`=0. Word index, word count and checksum are also cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Write latency: `code_w_en`=1 in cycle N+1 for a low byte strobed in cycle N. Address and data are valid in that same cycle and held until the next write.
- Run latency: `run` rises in cycle N+1 for a matching `CHK` strobed in cycle N.
- Error latency: `err` rises in cycle N+1 after the offending byte.
- Back-to-back `rx_valid` on consecutive cycles is legal. Every strobe must be consumed with no byte dropped; the loader applies no backpressure.
- `rst` has priority over `rx_valid` in the same cycle. That byte is discarded.
- `rst` mid-frame, in `RUN` or in `ERR` returns to `IDLE` in the next cycle with all outputs at reset values. Partially written code memory is not cleared.
- `run` falls in the cycle after `rst` is sampled high.

## Test plan

- Single word: bytes 00,01,12,34,27 -> one `code_w_en` pulse with addr 0, data 0x1234. Then `run`=1 one cycle after the `CHK` strobe; `err`=0.
- Three words 0xA001,0xB002,0xC003, bytes strobed on consecutive cycles with correct CHK -> writes at addr 0,1,2 with those values, each one cycle after its low byte. `busy` drops and `run` rises after CHK.
- Bad checksum: the single-word frame with CHK=0x28 -> the write still occurs. Then `err`=1, `run`=0, `busy`=0; later bytes produce no writes.
- Bad count: CNT 00,00 -> `err`=1 after the second byte. CNT 02,01 (513) -> `err`=1. CNT_HI=0x04 -> `err`=1 after `CNT_LO`. No writes in any case.
- Max image: 512 words with data = addr ^ 0x5A5A and correct CHK -> the last write is addr 511; `run`=1 and there is no address wrap.
- Reset mid-load: `rst` pulsed after 2 of 4 words -> outputs return to reset values the next cycle. A fresh two-word frame then loads at addr 0,1 and asserts `run`. `rst` coincident with a `rx_valid` strobe -> that byte is ignored.
